// File: rtl/key_event_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_event_decoder                                             |
// | Purpose  : Turns press-detector outputs into SINGLE / DOUBLE / LONG key  |
// |            events held in a one-deep valid/ready output register.        |
// | Ports    : clk          - system clock, rising edge                      |
// |            rst_n        - asynchronous active-low reset                  |
// |            short_press  - one-cycle pulse on release of a short press    |
// |            long_press   - level, high while key held past long threshold |
// |            event_ready  - consumer accepts the pending event             |
// |            event_valid  - an event is pending (registered)               |
// |            event_code   - 01 SINGLE, 10 DOUBLE, 11 LONG, 00 when idle    |
// |            event_drop   - one-cycle pulse: a new event was discarded     |
// | Params   : DOUBLE_WINDOW - double-click window in clk cycles (>= 2)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_event_decoder #(
  parameter logic [31:0] DOUBLE_WINDOW = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       short_press,
  input  logic       long_press,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       event_drop
);

  localparam logic [1:0]  C_CODE_NONE   = 2'b00;
  localparam logic [1:0]  C_CODE_SINGLE = 2'b01;
  localparam logic [1:0]  C_CODE_DOUBLE = 2'b10;
  localparam logic [1:0]  C_CODE_LONG   = 2'b11;
  // Last counter value still inside the double-click window.
  localparam logic [31:0] C_WIN_LAST    = DOUBLE_WINDOW - 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT2    = 2'd1,
    ST_LONGHOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_win_cnt;
  logic [31:0] w_win_cnt_next;
  logic        r_long_prev;
  logic        w_long_rise;

  logic        w_dec_valid;
  logic [1:0]  w_dec_code;

  logic        w_load;
  logic        w_drop;
  logic        w_release;

  logic        r_valid;
  logic [1:0]  r_code;
  logic        r_drop;

  // A long press already high when reset lifts counts as a rising edge,
  // because the history register comes out of reset at 0.
  assign w_long_rise = long_press & ~r_long_prev;

  // --------------------------------------------------------------------------
  // FSM state, window counter and long_press history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_win_cnt   <= 32'd0;
      r_long_prev <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_win_cnt   <= w_win_cnt_next;
      r_long_prev <= long_press;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and event decode
  //
  // The window counter numbers the cycles since the first short press, with
  // the press cycle itself as cycle 0. The register therefore already holds 1
  // in the first WAIT2 cycle, and the window closes in the cycle where it
  // equals DOUBLE_WINDOW-1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_win_cnt_next = r_win_cnt;
    w_dec_valid    = 1'b0;
    w_dec_code     = C_CODE_NONE;

    case (r_state)
      ST_IDLE: begin
        // LONG outranks a coincident short press.
        if (w_long_rise) begin
          w_dec_valid  = 1'b1;
          w_dec_code   = C_CODE_LONG;
          w_state_next = ST_LONGHOLD;
        end else if (short_press) begin
          w_state_next   = ST_WAIT2;
          w_win_cnt_next = 32'd1;
        end
      end

      ST_WAIT2: begin
        // LONG abandons the pending SINGLE; DOUBLE beats window expiry.
        if (w_long_rise) begin
          w_dec_valid    = 1'b1;
          w_dec_code     = C_CODE_LONG;
          w_state_next   = ST_LONGHOLD;
          w_win_cnt_next = 32'd0;
        end else if (short_press) begin
          w_dec_valid    = 1'b1;
          w_dec_code     = C_CODE_DOUBLE;
          w_state_next   = ST_IDLE;
          w_win_cnt_next = 32'd0;
        end else if (r_win_cnt == C_WIN_LAST) begin
          w_dec_valid    = 1'b1;
          w_dec_code     = C_CODE_SINGLE;
          w_state_next   = ST_IDLE;
          w_win_cnt_next = 32'd0;
        end else begin
          w_win_cnt_next = r_win_cnt + 32'd1;
        end
      end

      ST_LONGHOLD: begin
        // Short presses here are release artefacts of the long hold.
        if (!long_press) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_win_cnt_next = 32'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register: one-deep, accepts a new event in the same cycle the
  // current one is consumed so back-to-back events have no bubble.
  // --------------------------------------------------------------------------
  assign w_load    = w_dec_valid & (~r_valid | event_ready);
  assign w_drop    = w_dec_valid & r_valid & ~event_ready;
  assign w_release = ~w_dec_valid & r_valid & event_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= C_CODE_NONE;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_dec_code;
      end else if (w_release) begin
        r_valid <= 1'b0;
        r_code  <= C_CODE_NONE;
      end
    end
  end

  assign event_valid = r_valid;
  assign event_code  = r_code;
  assign event_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_event_decoder                                          |
// | Purpose  : Self-checking bench for key_event_decoder, DOUBLE_WINDOW = 8. |
// |            A vector table covers the main event types; hand-written      |
// |            sequences cover back-pressure, drops and reset corner cases.  |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_event_decoder;

  localparam logic [31:0] DW     = 32'd8;
  localparam int          N_VEC  = 71;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       short_press;
  logic       long_press;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_drop;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sp;
    logic       lp;
    logic       rdy;
    logic       ev;
    logic [1:0] ec;
    logic       ed;
  } vec_t;

  vec_t vecs [N_VEC];

  key_event_decoder #(.DOUBLE_WINDOW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .short_press (short_press),
    .long_press  (long_press),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_drop  (event_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ev, input logic [1:0] ec, input logic ed);
    n_checks++;
    if (event_valid !== ev || event_code !== ec || event_drop !== ed) begin
      n_fail++;
      $display("FAIL %s: got valid=%b code=%b drop=%b, expected valid=%b code=%b drop=%b",
               name, event_valid, event_code, event_drop, ev, ec, ed);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge, sampled by the next
  // edge; outputs are then read 1 time unit after that edge.
  task automatic step(input logic sp, input logic lp, input logic rdy);
    short_press = sp;
    long_press  = lp;
    event_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("reset_state", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    short_press = 1'b0;
    long_press  = 1'b0;
    event_ready = 1'b1;

    // ---------------- vector table ----------------
    // vecs[i] inputs are sampled at edge i; expected outputs follow that edge.
    for (int i = 0; i < N_VEC; i++) begin
      vecs[i].sp  = 1'b0;
      vecs[i].lp  = 1'b0;
      vecs[i].rdy = 1'b1;
      vecs[i].ev  = 1'b0;
      vecs[i].ec  = 2'b00;
      vecs[i].ed  = 1'b0;
    end
    // Lone short press at 0: SINGLE visible in cycle 8 only.
    vecs[0].sp  = 1'b1;
    vecs[7].ev  = 1'b1;
    vecs[7].ec  = 2'b01;
    // Shorts at 12 and 19 (window cycles 0 and 7): DOUBLE in cycle 20, no SINGLE.
    vecs[12].sp = 1'b1;
    vecs[19].sp = 1'b1;
    vecs[19].ev = 1'b1;
    vecs[19].ec = 2'b10;
    // Short at 24, long held 27..44, short at 45 ignored: LONG in cycle 28 only.
    vecs[24].sp = 1'b1;
    for (int i = 27; i <= 44; i++) vecs[i].lp = 1'b1;
    vecs[27].ev = 1'b1;
    vecs[27].ec = 2'b11;
    vecs[45].sp = 1'b1;
    // Short and long rise together in IDLE: LONG only, no later SINGLE.
    vecs[56].sp = 1'b1;
    for (int i = 56; i <= 59; i++) vecs[i].lp = 1'b1;
    vecs[56].ev = 1'b1;
    vecs[56].ec = 2'b11;

    do_reset();
    for (int i = 0; i < N_VEC; i++) begin
      step(vecs[i].sp, vecs[i].lp, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ed);
    end

    // ---------------- back-pressure: drop of a second DOUBLE ----------------
    do_reset();
    step(1'b1, 1'b0, 1'b0); check("bp_c0", 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b0); check("bp_c1", 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0); check("bp_double1", 1'b1, 2'b10, 1'b0);
    for (int c = 3; c <= 9; c++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("bp_hold_c%0d", c), 1'b1, 2'b10, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0); check("bp_c10", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b0); check("bp_c11", 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b0, 1'b0); check("bp_drop_pulse", 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b0, 1'b0); check("bp_drop_one_cycle", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b1); check("bp_release", 1'b0, 2'b00, 1'b0);

    // Pending DOUBLE, LONG rises while not ready: LONG dropped, DOUBLE kept.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); check("bp_pend_double", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b1, 1'b0); check("bp_long_dropped", 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b0, 1'b1); check("bp_long_exit_release", 1'b0, 2'b00, 1'b0);
    // Pending DOUBLE, LONG rises with ready: replaced with no bubble.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); check("b2b_pend_double", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b1, 1'b1); check("b2b_long_loaded", 1'b1, 2'b11, 1'b0);
    step(1'b0, 1'b0, 1'b1); check("b2b_release", 1'b0, 2'b00, 1'b0);

    // ---------------- back-to-back DOUBLE with ready at cycle 12 ----------------
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); check("b2b2_double1", 1'b1, 2'b10, 1'b0);
    for (int c = 3; c <= 11; c++) begin
      step((c == 10) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
    check("b2b2_c11", 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b0, 1'b1); check("b2b2_reload_no_drop", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b0); check("b2b2_new_held", 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b1); check("b2b2_release", 1'b0, 2'b00, 1'b0);

    // ---------------- reset mid-window discards pending SINGLE ----------------
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b1); check("rst_win_c4", 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1); check("rst_win_c5", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int c = 6; c <= 20; c++) begin
      step(1'b0, 1'b0, 1'b1);
      check($sformatf("rst_win_quiet_c%0d", c), 1'b0, 2'b00, 1'b0);
    end

    // ---------------- reset mid-hold, long still high at release ----------------
    do_reset();
    step(1'b0, 1'b1, 1'b0); check("hold_long", 1'b1, 2'b11, 1'b0);
    rst_n = 1'b0;
    #2;
    check("async_reset_clears", 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b1); check("hold_in_reset", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1); check("long_at_release", 1'b1, 2'b11, 1'b0);
    step(1'b0, 1'b1, 1'b1); check("long_once", 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b1); check("hold_exit_short_ignored", 1'b0, 2'b00, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b1);
    check("hold_exit_no_single", 1'b0, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
